// File: rtl/clock_pkg.sv
// clock_pkg: BCD field type, mode encoding, field limits and BCD helpers
package clock_pkg;
  typedef logic [7:0] bcd2_t;
  typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} clk_mode_e;
  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;
  function automatic bcd2_t bcd_next(input bcd2_t v, input bcd2_t max);
    return (v == max) ? 8'h00 :
           (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction
  function automatic bcd2_t bcd_to_12h(input bcd2_t h);
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    b = (b == 5'd0) ? 5'd12 : (b > 5'd12) ? b - 5'd12 : b;
    return (b >= 5'd10) ? {4'h1, 4'(b - 5'd10)} : {4'h0, b[3:0]};
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping MAX->00; wrap flags an increment at MAX
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = SEC_MAX
) (
  input  logic  clk,
  input  logic  rst_n,
  input  bcd2_t init,
  input  logic  inc,
  input  logic  load_zero,
  output bcd2_t q,
  output logic  wrap
);
  assign wrap = inc && (q == MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= init;
    else if (load_zero) q <= 8'h00;
    else if (inc) q <= bcd_next(q, MAX);
endmodule

// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd: BCD HH:MM:SS time-of-day with time/alarm set modes, ringing alarm,
// 12/24-hour display and a day-wrap pulse
module time_keeper_bcd
  import clock_pkg::*;
#(
  parameter bcd2_t INIT_HH   = 8'h12,
  parameter bcd2_t INIT_MM   = 8'h00,
  parameter bcd2_t INIT_SS   = 8'h00,
  parameter int    ALARM_LEN = 30
) (
  input  logic       clk_1Hz,
  input  logic       i_rst_n,
  input  logic       i_set_mode,
  input  logic       i_alarm_sel,
  input  logic       i_inc_hh,
  input  logic       i_inc_mm,
  input  logic       i_inc_ss,
  input  logic       i_alarm_en,
  input  logic       i_fmt12,
  output logic [7:0] o_hh_bcd,
  output logic [7:0] o_mm_bcd,
  output logic [7:0] o_ss_bcd,
  output logic       o_pm,
  output logic       o_alarm,
  output logic       o_day_tick
);
  clk_mode_e r_state, w_nxt_state;
  logic w_adv, w_edit_t, w_edit_a, w_clr_ss, w_trig;
  logic w_ss_wrap, w_mm_wrap, w_hh_wrap;
  logic [1:0] w_unused_al_wrap;
  bcd2_t w_hh, w_mm, w_ss, w_al_hh, w_al_mm;
  logic [7:0] r_ring;
  logic r_alarm, r_day_tick;
  always_ff @(posedge clk_1Hz or negedge i_rst_n)
    if (!i_rst_n) r_state <= RUN;
    else r_state <= w_nxt_state;
  always_comb begin
    w_nxt_state = !i_set_mode ? RUN : i_alarm_sel ? SET_ALARM : SET_TIME;
    w_adv       = (r_state == RUN) && !i_set_mode;
    w_edit_t    = (r_state == SET_TIME) && i_set_mode;
    w_edit_a    = (r_state == SET_ALARM) && i_set_mode;
    w_clr_ss    = (r_state == SET_TIME) && !i_set_mode;
  end
  // carries only propagate while running; edits never carry into the next field
  bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clk(clk_1Hz), .rst_n(i_rst_n), .init(INIT_SS),
    .inc(w_adv || (w_edit_t && i_inc_ss)), .load_zero(w_clr_ss),
    .q(w_ss), .wrap(w_ss_wrap)
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
    .clk(clk_1Hz), .rst_n(i_rst_n), .init(INIT_MM),
    .inc(w_adv ? w_ss_wrap : (w_edit_t && i_inc_mm)), .load_zero(1'b0),
    .q(w_mm), .wrap(w_mm_wrap)
  );
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hh (
    .clk(clk_1Hz), .rst_n(i_rst_n), .init(INIT_HH),
    .inc(w_adv ? w_mm_wrap : (w_edit_t && i_inc_hh)), .load_zero(1'b0),
    .q(w_hh), .wrap(w_hh_wrap)
  );
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_al_hh (
    .clk(clk_1Hz), .rst_n(i_rst_n), .init(8'h00),
    .inc(w_edit_a && i_inc_hh), .load_zero(1'b0),
    .q(w_al_hh), .wrap(w_unused_al_wrap[1])
  );
  bcd_mod_counter #(.MAX(MIN_MAX)) u_al_mm (
    .clk(clk_1Hz), .rst_n(i_rst_n), .init(8'h00),
    .inc(w_edit_a && i_inc_mm), .load_zero(1'b0),
    .q(w_al_mm), .wrap(w_unused_al_wrap[0])
  );
  // match against the time this advance lands on: only possible when ss rolls to 00
  assign w_trig = w_adv && i_alarm_en && (w_ss == SEC_MAX) &&
                  (bcd_next(w_mm, MIN_MAX) == w_al_mm) &&
                  (((w_mm == MIN_MAX) ? bcd_next(w_hh, HOUR_MAX) : w_hh) == w_al_hh);
  always_ff @(posedge clk_1Hz or negedge i_rst_n)
    if (!i_rst_n) begin
      r_alarm    <= 1'b0;
      r_ring     <= 8'd0;
      r_day_tick <= 1'b0;
    end else begin
      r_day_tick <= w_adv && w_hh_wrap;
      if (!i_alarm_en || i_set_mode) begin
        r_alarm <= 1'b0;
        r_ring  <= 8'd0;
      end else if (w_trig) begin
        r_alarm <= 1'b1;
        r_ring  <= 8'(ALARM_LEN - 1);
      end else if (r_ring != 8'd0) r_ring <= r_ring - 8'd1;
      else r_alarm <= 1'b0;
    end
  assign o_hh_bcd   = i_fmt12 ? bcd_to_12h(w_hh) : w_hh;
  assign o_mm_bcd   = w_mm;
  assign o_ss_bcd   = w_ss;
  assign o_pm       = i_fmt12 && (w_hh >= 8'h12);
  assign o_alarm    = r_alarm;
  assign o_day_tick = r_day_tick;
endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb_time_keeper_bcd: directed + random stimulus; a seconds-of-day reference model feeds
// a scoreboard queue that a separate monitor drains and compares
module tb_time_keeper_bcd;
  localparam int LEN    = 30;
  localparam int INIT_T = 12 * 3600;
  logic clk = 0, rst_n = 0, set_mode = 0, alarm_sel = 0;
  logic inc_hh = 0, inc_mm = 0, inc_ss = 0, alarm_en = 0, fmt12 = 0;
  logic [7:0] hh, mm, ss;
  logic pm, alarm, day_tick;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] hh, mm, ss;
    logic pm, alarm, day;
  } exp_t;
  exp_t sb[$];
  event mon_ev;
  int m_t, m_al, m_rem, m_st;
  logic m_day;

  time_keeper_bcd dut (
    .clk_1Hz(clk), .i_rst_n(rst_n), .i_set_mode(set_mode), .i_alarm_sel(alarm_sel),
    .i_inc_hh(inc_hh), .i_inc_mm(inc_mm), .i_inc_ss(inc_ss), .i_alarm_en(alarm_en),
    .i_fmt12(fmt12), .o_hh_bcd(hh), .o_mm_bcd(mm), .o_ss_bcd(ss), .o_pm(pm),
    .o_alarm(alarm), .o_day_tick(day_tick)
  );

  always #5 clk = ~clk;
  always @(negedge clk) -> mon_ev;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int h, dh;
    h  = m_t / 3600;
    dh = !fmt12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    e.hh = to_bcd(dh);
    e.mm = to_bcd((m_t / 60) % 60);
    e.ss = to_bcd(m_t % 60);
    e.pm = fmt12 && (h >= 12);
    e.alarm = m_rem > 0;
    e.day = m_day;
    return e;
  endfunction

  // reference: time as seconds of day, alarm as minute of day, ring as cycles remaining
  task automatic model_edge();
    int h, m, s;
    bit adv, trig;
    adv = (m_st == 0) && !set_mode;
    m_day = 0;
    trig = 0;
    if (adv) begin
      m_t = (m_t + 1) % 86400;
      m_day = (m_t == 0);
      trig = alarm_en && (m_t == m_al * 60);
    end
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    if (set_mode && m_st == 1)
      m_t = ((h + int'(inc_hh)) % 24) * 3600 + ((m + int'(inc_mm)) % 60) * 60 + (s + int'(inc_ss)) % 60;
    if (set_mode && m_st == 2)
      m_al = ((m_al / 60 + int'(inc_hh)) % 24) * 60 + (m_al % 60 + int'(inc_mm)) % 60;
    if (!set_mode && m_st == 1) m_t = m_t - s;
    if (!alarm_en || set_mode) m_rem = 0;
    else if (trig) m_rem = LEN;
    else if (m_rem > 0) m_rem--;
    m_st = !set_mode ? 0 : alarm_sel ? 2 : 1;
  endtask

  task automatic step(input bit sm, input bit sel, input bit ih, input bit im, input bit is,
                      input bit en, input bit f);
    @(negedge clk);
    #1;
    set_mode = sm; alarm_sel = sel; inc_hh = ih; inc_mm = im; inc_ss = is;
    alarm_en = en; fmt12 = f;
    @(posedge clk);
    model_edge();
    sb.push_back(expect_now());
  endtask

  // reset pulse wholly inside the low phase, checked before any edge, then one edge
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    m_t = INIT_T; m_al = 0; m_rem = 0; m_st = 0; m_day = 0;
    #1 sb.push_back(expect_now());
    -> mon_ev;
    #1 rst_n = 1;
    @(posedge clk);
    model_edge();
    sb.push_back(expect_now());
  endtask

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic wait_ring(input bit f);
    for (int i = 0; i < 200 && m_rem == 0; i++) step(0, 0, 0, 0, 0, 1, f);
    checks++;
    if (m_rem == 0) begin
      errors++;
      $display("FAIL alarm_wait: model alarm never started within 200 edges");
    end
  endtask

  initial forever begin
    @(mon_ev);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("hh", hh, e.hh);
      chk("mm", mm, e.mm);
      chk("ss", ss, e.ss);
      chk("pm", 8'(pm), 8'(e.pm));
      chk("alarm", 8'(alarm), 8'(e.alarm));
      chk("day_tick", 8'(day_tick), 8'(e.day));
    end
  end

  initial begin
    do_reset();
    repeat (3660) step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("run_hh", hh, 8'h13);
    chk("run_mm", mm, 8'h01);
    chk("run_ss", ss, 8'h01);
    chk("run_pm", 8'(pm), 8'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 58; i++) step(1, 0, i < 10, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    #1 chk("set_mm_wrap", mm, 8'h00);
    chk("set_hh_hold", hh, 8'h23);
    for (int i = 0; i < 59; i++) step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("exit_ss_clr", ss, 8'h00);
    repeat (59) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap_hh", hh, 8'h00);
    chk("wrap_tick", 8'(day_tick), 8'h01);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap_tick_end", 8'(day_tick), 8'h00);
    step(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) step(1, 1, i < 7, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++) step(1, 0, 1, i < 29, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (59) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    #1 chk("alarm_rise", 8'(alarm), 8'h01);
    repeat (29) step(0, 0, 0, 0, 0, 1, 0);
    #1 chk("alarm_last", 8'(alarm), 8'h01);
    step(0, 0, 0, 0, 0, 1, 0);
    #1 chk("alarm_fall", 8'(alarm), 8'h00);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    wait_ring(0);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("alarm_drop", 8'(alarm), 8'h00);
    step(1, 1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    wait_ring(1);
    repeat (3) step(0, 0, 0, 0, 0, 1, 1);
    do_reset();
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 1, 1, 1, 1);
    do_reset();
    for (int k = 0; k < 60; k++) begin
      int kind, n;
      bit sel;
      kind = $urandom_range(0, 9);
      n = $urandom_range(5, 60);
      sel = 1'($urandom_range(0, 1));
      if (kind < 6)
        repeat (n) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
      else if (kind < 9)
        repeat (n / 4 + 2) step(1, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else do_reset();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_keeper_bcd.md
# time_keeper_bcd

Parametrised time-of-day core for the FPGA digital clock. It keeps HH:MM:SS directly in BCD counters advanced by the 1 Hz tick, so no divide/modulo logic is needed. It adds a time-set mode, an alarm-set mode, an alarm with a programmable ring length, a 12/24-hour display format and a day-wrap pulse. Its BCD outputs feed the existing scan/segment-decode path.

## Interface
- INIT_HH, 8'h12: BCD hour loaded on reset (00–23).
- INIT_MM, 8'h00: BCD minute loaded on reset (00–59).
- INIT_SS, 8'h00: BCD second loaded on reset (00–59).
- ALARM_LEN, 30: number of clk_1Hz cycles o_alarm stays high; range 1–255.
- clk_1Hz  in  1  1 Hz system tick, rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_set_mode  in  1  level; 1 = set mode, time frozen.
- i_alarm_sel  in  1  level; in set mode, 1 = edit the alarm, 0 = edit the time.
- i_inc_hh, i_inc_mm, i_inc_ss  in  1 each  debounced levels sampled per edge; increment the selected field.
- i_alarm_en  in  1  alarm armed.
- i_fmt12  in  1  1 = 12-hour display, 0 = 24-hour display.
- o_hh_bcd, o_mm_bcd, o_ss_bcd  out  8 each  displayed field, [7:4] tens, [3:0] ones.
- o_pm  out  1  12-hour mode and hour ≥ 12.
- o_alarm  out  1  alarm ringing.
- o_day_tick  out  1  one-cycle pulse on 23:59:59→00:00:00.

## Operation
- FSM state register with states RUN, SET_TIME, SET_ALARM; reset value RUN.
  - Next state = RUN if i_set_mode=0.
  - Otherwise next state = SET_ALARM if i_alarm_sel=1, else SET_TIME.
- Time advance: on an edge, time advances by +1 s only if state=RUN and i_set_mode=0.
  - Carry chain is ss 59→00, then mm +1.
  - mm 59→00, then hh +1.
  - hh 23→00, with o_day_tick=1 on that edge.
- Set mode, in SET_TIME or SET_ALARM: each asserted i_inc_* adds 1 to its field, modulo 60 or 24, with no carry into the next field. Simultaneous increments all apply.
  - SET_TIME edits hh/mm/ss.
  - SET_ALARM edits alarm hh/mm; i_inc_ss is ignored.
- Leaving SET_TIME (edge with i_set_mode=0): ss cleared to 00. Counting resumes on the following edge.
- Alarm registers reset to 00:00.
- Alarm trigger: on a RUN advance whose new time equals alarm_hh:alarm_mm:00 while i_alarm_en=1, o_alarm goes 1 and a ring counter loads ALARM_LEN-1.
- Alarm timing: o_alarm stays 1 while the ring counter is non-zero and decrements each edge. It falls on the edge where the counter is 0.
- Alarm cleared: o_alarm is cleared immediately (same edge) if i_alarm_en=0 or i_set_mode=1 is sampled.
- Display conversion is combinational from the registers and i_fmt12:
  - 24-hour mode: hour passes through; o_pm=0.
  - 12-hour mode: 00→12, 13..23→01..11, 12 stays 12; o_pm = hour≥12.
- The internal hour is always kept 00–23.
- Reset value of every output:
  - o_hh_bcd = INIT_HH, or its 12-hour form if i_fmt12=1.
  - o_mm_bcd = INIT_MM, o_ss_bcd = INIT_SS.
  - o_pm = 0 unless i_fmt12=1 and INIT_HH≥12.
  - o_alarm = 0, o_day_tick = 0.

## Timing
- Latency: a register change is visible on outputs in the same cycle, i.e. right after the edge. Display conversion adds no cycle.
- Reset mid-operation: immediately restores INIT time, alarm 00:00, state RUN, ring counter 0. Edits in progress are lost.
- Simultaneous events:
  - An alarm match on the day-wrap edge (alarm 00:00) both pulses o_day_tick and starts the alarm.
  - i_set_mode=1 takes priority over advance and over alarm start.
- No handshake: inputs are levels. The upstream debouncer delivers one-cycle-of-clk_1Hz pulses per key press.

## Structure
- Package clock_pkg holds:
  - typedef bcd2_t (logic [7:0]).
  - enum clk_mode_e {RUN, SET_TIME, SET_ALARM}.
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23.
  - function bcd_to_12h.
- One sub-module, bcd_mod_counter #(MAX):
  - Inputs: clk, rst_n, init, inc, load_zero.
  - Outputs: q (bcd2_t), wrap.
- Instantiated three times for the time fields and twice for the alarm fields.

## Test plan
- Reset with defaults → outputs 12:00:00. Then 3661 edges in RUN → 13:01:01, o_pm=0 (24h).
- INIT 23:59:58, two edges → 23:59:59 then 00:00:00 with o_day_tick=1 for exactly one cycle.
- Set mode, SET_TIME, i_inc_mm pulsed at mm=59 → mm=00 and hh unchanged. Exit → ss=00, then 00:..:01 on the next edge.
- Alarm set to 07:30, i_alarm_en=1, time 07:29:59, one edge → o_alarm=1 for 30 edges (ALARM_LEN=30). With i_alarm_en dropped at ring edge 5 → low at edge 5.
- i_fmt12=1 across hours 00, 12, 13, 23 → displays 12/pm0, 12/pm1, 01/pm1, 11/pm1.
- Async reset asserted mid-ring and mid-set → all outputs at reset values with no clock edge.
